// File: rtl/seven_segment_scanner_if.sv
// Display-side bundle of the 7-segment scanner: digit data and controls in,
// cathode/anode drive and scan status out.
interface seven_segment_scanner_if #(
  parameter int NUM_DIGITS = 8
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [4*NUM_DIGITS-1:0] val_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic                    lz_en_in;
  logic [3:0]              brightness_in;
  logic [6:0]              cat_out;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   an_out;
  logic [IDX_W-1:0]        digit_idx_out;
  logic                    frame_done_out;

  modport master (
    output val_in, dp_in, blank_in, lz_en_in, brightness_in,
    input  cat_out, dp_out, an_out, digit_idx_out, frame_done_out
  );

  modport slave (
    input  val_in, dp_in, blank_in, lz_en_in, brightness_in,
    output cat_out, dp_out, an_out, digit_idx_out, frame_done_out
  );
endinterface

// File: rtl/seven_segment_scanner.sv
// Multiplexed common-anode 7-segment driver: per-slot guard blanking, 4-bit PWM,
// decimal points, per-digit blanking, leading-zero suppression, frame-coherent data.
module seven_segment_scanner #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100_000,
  parameter int GUARD      = 1_000
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  seven_segment_scanner_if.slave disp
);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W  = $clog2(SCAN_DIV);
  localparam int ACTIVE = SCAN_DIV - GUARD;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // Segment pattern {g,f,e,d,c,b,a}, active-high; pins take the complement.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b0111111;
      4'h1:    seg = 7'b0000110;
      4'h2:    seg = 7'b1011011;
      4'h3:    seg = 7'b1001111;
      4'h4:    seg = 7'b1100110;
      4'h5:    seg = 7'b1101101;
      4'h6:    seg = 7'b1111101;
      4'h7:    seg = 7'b0000111;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1101111;
      4'hA:    seg = 7'b1110111;
      4'hB:    seg = 7'b1111100;
      4'hC:    seg = 7'b0111001;
      4'hD:    seg = 7'b1011110;
      4'hE:    seg = 7'b1111001;
      default: seg = 7'b1110001;
    endcase
    return seg;
  endfunction

  logic [CNT_W-1:0]        slot_cnt;
  logic [IDX_W-1:0]        idx;
  logic                    slot_end;
  logic                    frame_end;
  logic [4*NUM_DIGITS-1:0] val_snap;
  logic [NUM_DIGITS-1:0]   dp_snap;
  logic [NUM_DIGITS-1:0]   blank_snap;
  logic                    lz_snap;
  logic [3:0]              bright_q;

  assign slot_end  = (slot_cnt == SLOT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (slot_end) begin
      slot_cnt <= '0;
      idx      <= frame_end ? '0 : idx + IDX_W'(1);
    end else begin
      slot_cnt <= slot_cnt + CNT_W'(1);
    end
  end

  // NOTE: snapshot registers are reset so the first frame after reset shows a defined all-zero pattern.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      val_snap   <= '0;
      dp_snap    <= '0;
      blank_snap <= '0;
      lz_snap    <= 1'b0;
      bright_q   <= 4'hF;
    end else begin
      if (frame_end) begin
        val_snap   <= disp.val_in;
        dp_snap    <= disp.dp_in;
        blank_snap <= disp.blank_in;
        lz_snap    <= disp.lz_en_in;
      end
      if (slot_cnt == '0) bright_q <= disp.brightness_in;
    end
  end

  logic [3:0]            bright_eff;
  logic [31:0]           on_cycles;
  logic [31:0]           cnt_ext;
  logic                  in_window;
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] dark;
  logic [3:0]            nibble;
  logic                  lit;
  logic [NUM_DIGITS-1:0] an_d;
  logic [6:0]            cat_d;
  logic                  dp_d;

  always_comb begin
    // NOTE: every variable gets a value before any branch, so no path can infer a latch.
    an_d  = '1;
    cat_d = 7'h7F;
    dp_d  = 1'b1;
    // The latch is only written at the end of cycle 0, so cycle 0 reads the input directly.
    bright_eff = (slot_cnt == '0) ? disp.brightness_in : bright_q;
    on_cycles  = (32'(ACTIVE) * (32'(bright_eff) + 32'd1)) >> 4;
    cnt_ext    = 32'(slot_cnt);
    in_window  = (cnt_ext >= 32'(GUARD)) && (cnt_ext < 32'(GUARD) + on_cycles);
    // Walk from the most significant digit down; zero_run stays set while all higher nibbles are zero.
    zero_run = lz_snap;
    dark     = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (val_snap[4*i +: 4] == 4'h0);
      dark[i]  = blank_snap[i] || (zero_run && (i != 0));
    end
    nibble = val_snap[{idx, 2'b00} +: 4];
    lit    = in_window && !dark[idx];
    if (lit) begin
      an_d[idx] = 1'b0;
      cat_d     = ~glyph(nibble);
      dp_d      = ~dp_snap[idx];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      disp.an_out         <= '1;
      disp.cat_out        <= 7'h7F;
      disp.dp_out         <= 1'b1;
      disp.digit_idx_out  <= '0;
      disp.frame_done_out <= 1'b0;
    end else begin
      disp.an_out         <= an_d;
      disp.cat_out        <= cat_d;
      disp.dp_out         <= dp_d;
      disp.digit_idx_out  <= idx;
      disp.frame_done_out <= frame_end;
    end
  end
endmodule
